// File: rtl/tlb_array.sv
// Fully-associative dual-page TLB: combinational search, write port, registered read port
// and a one-entry-per-cycle INVTLB sweep engine.
module tlb_array #(
    parameter int TLBNUM = 16,
    parameter int IDXW   = 4
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic [18:0]     s_vppn,
    input  logic            s_va_bit12,
    input  logic [9:0]      s_asid,
    output logic            s_found,
    output logic [IDXW-1:0] s_index,
    output logic [19:0]     s_ppn,
    output logic [5:0]      s_ps,
    output logic [1:0]      s_plv,
    output logic [1:0]      s_mat,
    output logic            s_d,
    output logic            s_v,
    input  logic            we,
    input  logic [IDXW-1:0] w_index,
    input  logic [36:0]     w_hi,
    input  logic [25:0]     w_lo0,
    input  logic [25:0]     w_lo1,
    input  logic            r_en,
    input  logic [IDXW-1:0] r_index,
    output logic            r_valid,
    output logic [36:0]     r_hi,
    output logic [25:0]     r_lo0,
    output logic [25:0]     r_lo1,
    input  logic            inv_req,
    input  logic [4:0]      inv_op,
    input  logic [9:0]      inv_asid,
    input  logic [18:0]     inv_vppn,
    output logic            inv_busy
);

    // HI layout: [36]=E [35:17]=VPPN [16:11]=PS [10:1]=ASID [0]=G
    logic [36:0] hi  [TLBNUM];
    logic [25:0] lo0 [TLBNUM];
    logic [25:0] lo1 [TLBNUM];

    typedef enum logic {IDLE, SWEEP} state_t;
    state_t          state;
    logic [IDXW-1:0] ptr;
    logic [4:0]      cur_op;
    logic [9:0]      cur_asid;
    logic [18:0]     cur_vppn;
    logic            inv_clear;
    logic [25:0]     page;

    function automatic logic va_match(input logic [36:0] h, input logic [18:0] vppn);
        if (h[16:11] == 6'd21)
            return h[35:26] == vppn[18:9];
        return h[35:17] == vppn;
    endfunction

    function automatic logic inv_hit(input logic [36:0] h, input logic [4:0] op,
                                     input logic [9:0] asid, input logic [18:0] vppn);
        logic g, am, vm;
        g  = h[0];
        am = (h[10:1] == asid);
        vm = va_match(h, vppn);
        case (op)
            5'd0, 5'd1: return 1'b1;
            5'd2:       return g;
            5'd3:       return !g;
            5'd4:       return !g && am;
            5'd5:       return !g && am && vm;
            5'd6:       return (g || am) && vm;
            default:    return 1'b0;
        endcase
    endfunction

    // Descending scan so the lowest matching index is the one left standing.
    always_comb begin
        s_found = 1'b0;
        s_index = '0;
        s_ps    = '0;
        page    = '0;
        for (int i = TLBNUM - 1; i >= 0; i--) begin
            if (hi[i][36] && (hi[i][0] || hi[i][10:1] == s_asid) && va_match(hi[i], s_vppn)) begin
                s_found = 1'b1;
                s_index = IDXW'(i);
                s_ps    = hi[i][16:11];
                if ((hi[i][16:11] == 6'd21) ? s_vppn[8] : s_va_bit12)
                    page = lo1[i];
                else
                    page = lo0[i];
            end
        end
    end

    assign s_ppn = page[25:6];
    assign s_plv = page[5:4];
    assign s_mat = page[3:2];
    assign s_d   = page[1];
    assign s_v   = page[0];

    assign inv_clear = (state == SWEEP) && inv_hit(hi[ptr], cur_op, cur_asid, cur_vppn);

    // Write is applied after the sweep clear so a colliding write wins.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < TLBNUM; i++) begin
                hi[i]  <= '0;
                lo0[i] <= '0;
                lo1[i] <= '0;
            end
        end else begin
            if (inv_clear)
                hi[ptr][36] <= 1'b0;
            if (we && 32'(w_index) < TLBNUM) begin
                hi[w_index]  <= w_hi;
                lo0[w_index] <= w_lo0;
                lo1[w_index] <= w_lo1;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_valid <= 1'b0;
            r_hi    <= '0;
            r_lo0   <= '0;
            r_lo1   <= '0;
        end else begin
            r_valid <= r_en;
            if (r_en) begin
                r_hi  <= hi[r_index];
                r_lo0 <= lo0[r_index];
                r_lo1 <= lo1[r_index];
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state    <= IDLE;
            ptr      <= '0;
            cur_op   <= '0;
            cur_asid <= '0;
            cur_vppn <= '0;
            inv_busy <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (inv_req && inv_op <= 5'd6) begin
                        cur_op   <= inv_op;
                        cur_asid <= inv_asid;
                        cur_vppn <= inv_vppn;
                        ptr      <= '0;
                        state    <= SWEEP;
                        inv_busy <= 1'b1;
                    end
                end
                SWEEP: begin
                    if (ptr == IDXW'(TLBNUM - 1)) begin
                        state    <= IDLE;
                        inv_busy <= 1'b0;
                    end else begin
                        ptr <= ptr + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
